// File: rtl/mrd_sink_ctrl.sv
// Input sink of the mixed-radix DFT: frames the ST_IN stream into a ping-pong buffer and hands full banks to compute.
// Optional per-frame statistics counters are enabled by defining MRD_SINK_ERRCNT_EN.
module mrd_sink_ctrl #(
    parameter int DW      = 18,
    parameter int PTS_W   = 12,
    parameter int AW      = 11,
    parameter int MIN_PTS = 12,
    parameter int MAX_PTS = 1200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [DW-1:0]    in_real,
    input  logic [DW-1:0]    in_imag,
    input  logic [PTS_W-1:0] in_dftpts,
    input  logic             in_inverse,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_real,
    output logic [DW-1:0]    wr_imag,
    output logic             frm_valid,
    output logic             frm_bank,
    output logic [PTS_W-1:0] frm_dftpts,
    output logic             frm_inverse,
    input  logic             frm_done,
    output logic             err_pts,
    output logic             err_len,
    output logic [15:0]      cnt_ok,
    output logic [15:0]      cnt_err
);

    typedef enum logic [1:0] {
        IDLE,
        SINK,
        DROP
    } state_t;

    state_t           state_q;
    logic             run_q;
    logic [PTS_W-1:0] cnt_q;
    logic [PTS_W-1:0] pts_q;
    logic             inv_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       full_q;
    logic [PTS_W-1:0] bank_pts_q [2];
    logic [1:0]       bank_inv_q;
    logic             pub_q;
    logic             pub_bank_q;
    logic             wr_en_q;
    logic             wr_bank_q;
    logic [AW-1:0]    wr_addr_q;
    logic [DW-1:0]    wr_real_q;
    logic [DW-1:0]    wr_imag_q;
    logic             err_pts_q;
    logic             err_len_q;

    logic             accept;
    logic             pts_legal;
    logic [PTS_W-1:0] cnt_next;
    logic             last_beat;
    logic             done_take;

    // run_q keeps in_ready low while reset is held without a combinational path from rst_n
    assign in_ready  = run_q & ((state_q != IDLE) | ~full_q[wr_ptr_q]);
    assign accept    = in_valid & in_ready;
    assign pts_legal = (in_dftpts >= PTS_W'(MIN_PTS)) && (in_dftpts <= PTS_W'(MAX_PTS));
    assign cnt_next  = cnt_q + PTS_W'(1);
    assign last_beat = (cnt_next == pts_q);
    assign done_take = frm_done & full_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            cnt_q         <= '0;
            pts_q         <= '0;
            inv_q         <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            full_q        <= 2'b00;
            bank_pts_q[0] <= '0;
            bank_pts_q[1] <= '0;
            bank_inv_q    <= 2'b00;
            pub_q         <= 1'b0;
            pub_bank_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_real_q     <= '0;
            wr_imag_q     <= '0;
            err_pts_q     <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            wr_en_q   <= 1'b0;
            err_pts_q <= 1'b0;
            err_len_q <= 1'b0;
            pub_q     <= 1'b0;

            // Publish targets the bank just written, release targets the bank under compute; they never collide
            if (pub_q && !pub_bank_q) begin
                full_q[0] <= 1'b1;
            end else if (done_take && !rd_ptr_q) begin
                full_q[0] <= 1'b0;
            end
            if (pub_q && pub_bank_q) begin
                full_q[1] <= 1'b1;
            end else if (done_take && rd_ptr_q) begin
                full_q[1] <= 1'b0;
            end
            if (done_take) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            if (accept) begin
                wr_real_q <= in_real;
                wr_imag_q <= in_imag;
                wr_bank_q <= wr_ptr_q;
                case (state_q)
                    IDLE: begin
                        if (in_sop) begin
                            if (!pts_legal) begin
                                err_pts_q <= 1'b1;
                                if (!in_eop) begin
                                    state_q <= DROP;
                                end
                            end else begin
                                pts_q     <= in_dftpts;
                                inv_q     <= in_inverse;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= '0;
                                cnt_q     <= PTS_W'(1);
                                if (in_eop) begin
                                    err_len_q <= 1'b1;
                                end else begin
                                    state_q <= SINK;
                                end
                            end
                        end
                    end
                    SINK: begin
                        if (in_sop) begin
                            // A new sop aborts the frame in progress and restarts the same bank
                            err_len_q <= 1'b1;
                            if (!pts_legal) begin
                                err_pts_q <= 1'b1;
                                state_q   <= in_eop ? IDLE : DROP;
                            end else begin
                                pts_q     <= in_dftpts;
                                inv_q     <= in_inverse;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= '0;
                                cnt_q     <= PTS_W'(1);
                                state_q   <= in_eop ? IDLE : SINK;
                            end
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cnt_q[AW-1:0];
                            cnt_q     <= cnt_next;
                            if (in_eop) begin
                                state_q <= IDLE;
                                if (last_beat) begin
                                    pub_q                <= 1'b1;
                                    pub_bank_q           <= wr_ptr_q;
                                    wr_ptr_q             <= ~wr_ptr_q;
                                    bank_pts_q[wr_ptr_q] <= pts_q;
                                    bank_inv_q[wr_ptr_q] <= inv_q;
                                end else begin
                                    err_len_q <= 1'b1;
                                end
                            end else if (last_beat) begin
                                err_len_q <= 1'b1;
                                state_q   <= DROP;
                            end
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_bank     = wr_bank_q;
    assign wr_addr     = wr_addr_q;
    assign wr_real     = wr_real_q;
    assign wr_imag     = wr_imag_q;
    assign err_pts     = err_pts_q;
    assign err_len     = err_len_q;
    assign frm_valid   = full_q[rd_ptr_q];
    assign frm_bank    = rd_ptr_q;
    assign frm_dftpts  = bank_pts_q[rd_ptr_q];
    assign frm_inverse = bank_inv_q[rd_ptr_q];

`ifdef MRD_SINK_ERRCNT_EN
    logic [15:0] cnt_ok_q;
    logic [15:0] cnt_err_q;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    // Both error pulses can fire on one beat, so the error counter may advance by two
    assign err_inc = {1'b0, err_pts_q} + {1'b0, err_len_q};
    assign err_sum = {1'b0, cnt_err_q} + {15'd0, err_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            if (pub_q && (cnt_ok_q != 16'hFFFF)) begin
                cnt_ok_q <= cnt_ok_q + 16'd1;
            end
            cnt_err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign cnt_ok  = cnt_ok_q;
    assign cnt_err = cnt_err_q;
`else
    assign cnt_ok  = '0;
    assign cnt_err = '0;
`endif

endmodule

// File: tb/tb_mrd_sink_ctrl.sv
// Self-checking bench for mrd_sink_ctrl: buffer writes are scoreboarded, frame hand-off and error pulses checked per scenario.
// Counter expectations follow MRD_SINK_ERRCNT_EN.
module tb_mrd_sink_ctrl;

    localparam int DW      = 18;
    localparam int PTS_W   = 12;
    localparam int AW      = 11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sop;
    logic             in_eop;
    logic [DW-1:0]    in_real;
    logic [DW-1:0]    in_imag;
    logic [PTS_W-1:0] in_dftpts;
    logic             in_inverse;
    logic             wr_en;
    logic             wr_bank;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_real;
    logic [DW-1:0]    wr_imag;
    logic             frm_valid;
    logic             frm_bank;
    logic [PTS_W-1:0] frm_dftpts;
    logic             frm_inverse;
    logic             frm_done;
    logic             err_pts;
    logic             err_len;
    logic [15:0]      cnt_ok;
    logic [15:0]      cnt_err;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } wr_t;

    wr_t expQ[$];
    wr_t monExp;
    int  checks     = 0;
    int  errors     = 0;
    int  errLenSeen = 0;
    int  errPtsSeen = 0;

    mrd_sink_ctrl #(
        .DW(DW), .PTS_W(PTS_W), .AW(AW), .MIN_PTS(12), .MAX_PTS(1200)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_real(in_real), .in_imag(in_imag), .in_dftpts(in_dftpts), .in_inverse(in_inverse),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_real(wr_real), .wr_imag(wr_imag),
        .frm_valid(frm_valid), .frm_bank(frm_bank), .frm_dftpts(frm_dftpts), .frm_inverse(frm_inverse),
        .frm_done(frm_done), .err_pts(err_pts), .err_len(err_len),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every buffer write must match the oldest expected write; error pulses are tallied per cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_len) errLenSeen++;
            if (err_pts) errPtsSeen++;
            if (wr_en) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got bank=%0d addr=%0d, required no write", wr_bank, wr_addr);
                end else begin
                    monExp = expQ.pop_front();
                    if ({wr_bank, wr_addr, wr_real, wr_imag} !== monExp) begin
                        errors++;
                        $display("[TB] FAIL write_data: got bank=%0d addr=%0d re=%h im=%h, required bank=%0d addr=%0d re=%h im=%h",
                                 wr_bank, wr_addr, wr_real, wr_imag, monExp.bank, monExp.addr, monExp.re, monExp.im);
                    end
                end
            end
        end
    end

    // Drives one beat from a negedge, waits for in_ready, and returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic sop, input logic eop, input logic [PTS_W-1:0] pts,
                                 input logic inv, input logic expWr, input logic bank, input int addr);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            guard;
        re = DW'($urandom);
        im = DW'($urandom);
        in_valid   = 1'b1;
        in_sop     = sop;
        in_eop     = eop;
        in_dftpts  = pts;
        in_inverse = inv;
        in_real    = re;
        in_imag    = im;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: in_ready=%b, required 1", in_ready);
        end else if (expWr) begin
            expQ.push_back({bank, AW'(addr), re, im});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends n beats with sop on the first; the first nWr beats are expected to land at addr 0.. in bank
    task automatic sendFrame(input int pts, input int n, input logic inv, input logic bank,
                             input int nWr, input logic withEop);
        for (int i = 0; i < n; i++) begin
            applyStimulus(i == 0, withEop && (i == n - 1), PTS_W'(pts), inv, i < nWr, bank, i);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseDone();
        frm_done = 1'b1;
        @(negedge clk);
        frm_done = 1'b0;
    endtask

    // Applies reset and flags any expected writes that never appeared
    task automatic doReset();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        frm_done = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_writes: got %0d pending, required 0", expQ.size());
        end
        expQ.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input logic expValid, input logic expBank,
                              input int expPts, input logic expInv);
        checks++;
        if (frm_valid !== expValid || (expValid && (frm_bank !== expBank || frm_dftpts !== PTS_W'(expPts)
                                                    || frm_inverse !== expInv))) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b bank=%b pts=%0d inv=%b, required valid=%b bank=%b pts=%0d inv=%b",
                     name, frm_valid, frm_bank, frm_dftpts, frm_inverse, expValid, expBank, expPts, expInv);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        frm_done   = 1'b0;
        in_valid   = 1'b1;
        in_sop     = 1'b1;
        in_eop     = 1'b0;
        in_dftpts  = 12'd12;
        in_inverse = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        repeat (3) @(negedge clk);
        checkBit("reset_in_ready", in_ready, 1'b0);
        checkBit("reset_wr_en", wr_en, 1'b0);
        checkFrame("reset_frame", 1'b0, 1'b0, 0, 1'b0);
        checkBit("reset_frm_bank", frm_bank, 1'b0);
        checkInt("reset_frm_dftpts", int'(frm_dftpts), 0);
        checkBit("reset_err", err_pts | err_len, 1'b0);
        checkInt("reset_cnt_ok", int'(cnt_ok), 0);
        checkInt("reset_cnt_err", int'(cnt_err), 0);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checkBit("ready_after_reset", in_ready, 1'b1);
    endtask

    task automatic test_legal_frame();
        int l0;
        int p0;
        doReset();
        l0 = errLenSeen;
        p0 = errPtsSeen;
        sendFrame(12, 12, 1'b1, 1'b0, 12, 1'b1);
        checkBit("publish_not_early", frm_valid, 1'b0);
        @(negedge clk);
        checkFrame("legal_publish", 1'b1, 1'b0, 12, 1'b1);
        idle(1);
        checkInt("legal_no_err_len", errLenSeen - l0, 0);
        checkInt("legal_no_err_pts", errPtsSeen - p0, 0);
        checkBit("legal_ready_next_bank", in_ready, 1'b1);
    endtask

    task automatic test_two_frames();
        doReset();
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        sendFrame(16, 16, 1'b1, 1'b1, 16, 1'b1);
        idle(2);
        checkBit("both_full_stall", in_ready, 1'b0);
        checkFrame("two_first_bank", 1'b1, 1'b0, 12, 1'b0);
        pulseDone();
        checkFrame("two_second_bank", 1'b1, 1'b1, 16, 1'b1);
        checkBit("ready_after_done", in_ready, 1'b1);
        pulseDone();
        checkBit("both_released", frm_valid, 1'b0);
        pulseDone();
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(1);
        checkFrame("done_ignored_when_empty", 1'b1, 1'b0, 12, 1'b0);
        pulseDone();
    endtask

    task automatic test_back_to_back();
        doReset();
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(1);
        sendFrame(20, 20, 1'b1, 1'b1, 20, 1'b1);
        frm_done = 1'b1;
        @(negedge clk);
        frm_done = 1'b0;
        checkFrame("done_with_publish", 1'b1, 1'b1, 20, 1'b1);
        checkBit("done_with_publish_ready", in_ready, 1'b1);
        pulseDone();
        checkBit("back_to_back_drained", frm_valid, 1'b0);
    endtask

    task automatic test_short_frame();
        int l0;
        doReset();
        l0 = errLenSeen;
        sendFrame(24, 10, 1'b0, 1'b0, 10, 1'b1);
        idle(2);
        checkInt("short_err_len", errLenSeen - l0, 1);
        checkBit("short_no_publish", frm_valid, 1'b0);
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(1);
        checkFrame("short_then_same_bank", 1'b1, 1'b0, 12, 1'b0);
    endtask

    task automatic test_illegal_size();
        int l0;
        int p0;
        doReset();
        l0 = errLenSeen;
        p0 = errPtsSeen;
        sendFrame(6, 5, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(1300, 4, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(1201, 2, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(11, 1, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(1);
        checkInt("illegal_err_pts", errPtsSeen - p0, 4);
        checkInt("illegal_no_err_len", errLenSeen - l0, 0);
        checkFrame("illegal_then_legal", 1'b1, 1'b0, 12, 1'b0);
    endtask

    task automatic test_overlong();
        int l0;
        doReset();
        l0 = errLenSeen;
        sendFrame(12, 15, 1'b0, 1'b0, 12, 1'b1);
        idle(2);
        checkInt("overlong_err_len", errLenSeen - l0, 1);
        checkBit("overlong_no_publish", frm_valid, 1'b0);
        sendFrame(13, 13, 1'b1, 1'b0, 13, 1'b1);
        idle(1);
        checkFrame("overlong_then_legal", 1'b1, 1'b0, 13, 1'b1);
    endtask

    task automatic test_mid_sop();
        int l0;
        doReset();
        l0 = errLenSeen;
        sendFrame(20, 5, 1'b0, 1'b0, 5, 1'b0);
        sendFrame(12, 12, 1'b1, 1'b0, 12, 1'b1);
        idle(1);
        checkInt("mid_sop_err_len", errLenSeen - l0, 1);
        checkFrame("mid_sop_restart", 1'b1, 1'b0, 12, 1'b1);
    endtask

    task automatic test_reset_midframe();
        doReset();
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        sendFrame(16, 6, 1'b0, 1'b1, 6, 1'b0);
        idle(1);
        doReset();
        checkBit("reset_clears_banks", frm_valid, 1'b0);
        checkBit("reset_ready", in_ready, 1'b1);
        sendFrame(14, 14, 1'b0, 1'b0, 14, 1'b1);
        idle(1);
        checkFrame("after_reset_bank0", 1'b1, 1'b0, 14, 1'b0);
    endtask

    task automatic test_counters();
        int expOk;
        int expErr;
`ifdef MRD_SINK_ERRCNT_EN
        expOk  = 3;
        expErr = 2;
`else
        expOk  = 0;
        expErr = 0;
`endif
        doReset();
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(1);
        pulseDone();
        sendFrame(12, 12, 1'b0, 1'b1, 12, 1'b1);
        idle(1);
        pulseDone();
        sendFrame(24, 10, 1'b0, 1'b0, 10, 1'b1);
        sendFrame(6, 3, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(12, 12, 1'b0, 1'b0, 12, 1'b1);
        idle(2);
        checkInt("cnt_ok", int'(cnt_ok), expOk);
        checkInt("cnt_err", int'(cnt_err), expErr);
    endtask

    initial begin
        test_reset();
        test_legal_frame();
        test_two_frames();
        test_back_to_back();
        test_short_frame();
        test_illegal_size();
        test_overlong();
        test_mid_sop();
        test_reset_midframe();
        test_counters();
        idle(2);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_writes_end: got %0d pending, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guards against a stuck run
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, required finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mrd_sink_ctrl.md
Name: mrd_sink_ctrl

Overview:
Input sink stage of the mixed radix DFT; sits directly upstream of the radix-2/3/4/5 compute engine.
- Accepts the ST_IN sample stream (valid/ready, sop/eop, d_real/d_imag, dftpts, inverse).
- Checks frame length against dftpts and writes samples into a two-bank (ping-pong) buffer.
- Hands each complete frame to the compute engine with its dftpts/inverse; releases the bank on completion.

Parameters:
DW, 18, sample component width
PTS_W, 12, width of dftpts
AW, 11, buffer address width per bank
MIN_PTS, 12, smallest legal dftpts
MAX_PTS, 1200, largest legal dftpts (must be < 2^AW)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  sink can accept
in_sop  in  1  first sample of frame
in_eop  in  1  last sample of frame
in_real  in  DW  sample real part
in_imag  in  DW  sample imaginary part
in_dftpts  in  PTS_W  frame size, sampled on sop
in_inverse  in  1  IDFT flag, sampled on sop
wr_en  out  1  buffer write strobe
wr_bank  out  1  bank being written
wr_addr  out  AW  sample index within bank
wr_real  out  DW  write data real
wr_imag  out  DW  write data imaginary
frm_valid  out  1  a full bank awaits compute
frm_bank  out  1  bank to compute
frm_dftpts  out  PTS_W  size of that frame
frm_inverse  out  1  inverse flag of that frame
frm_done  in  1  one-cycle pulse: compute finished with frm_bank
err_pts  out  1  one-cycle pulse: illegal dftpts on sop
err_len  out  1  one-cycle pulse: frame length mismatch
cnt_ok  out  16  frames published (optional feature)
cnt_err  out  16  errors seen (optional feature)

Behaviour:
- Reset: all outputs 0, FSM=IDLE, both bank-full flags 0, write and read bank pointers 0, in_ready=0 during reset.
- Accept = in_valid & in_ready.
- Latency: wr_* registered, one cycle after accept. err_* pulse one cycle after the offending accept.
- FSM IDLE: in_ready=1 iff bank[wr_ptr] not full.
  - Accepted sample without sop: discarded, no write.
  - Accepted sop with in_dftpts < MIN_PTS or > MAX_PTS: err_pts, latch nothing, go DROP. If eop is on the same beat, stay IDLE.
  - Accepted legal sop: latch dftpts/inverse, write addr 0, cnt=1, go SINK.
- FSM SINK: in_ready=1. Each accept writes addr=cnt, cnt++.
  - eop with cnt+1==dftpts: publish bank (full flag set), toggle wr_ptr, go IDLE.
  - eop with cnt+1<dftpts: err_len, bank not published, go IDLE.
  - No eop with cnt+1==dftpts: err_len, go DROP.
  - sop mid-frame: err_len, abort current frame, restart in same bank with this sample at addr 0. The new dftpts is range-checked as in IDLE.
- FSM DROP: in_ready=1, no writes, return to IDLE on accepted eop.
- Publish timing: bank full flag and frm_valid rise the cycle after the last wr_en (two cycles after eop accept).
- frm_valid = bank[rd_ptr] full; frm_bank=rd_ptr; frm_dftpts/frm_inverse held per bank and stable while frm_valid.
- frm_done: clears bank[rd_ptr] full, toggles rd_ptr. Ignored when frm_valid=0.
- frm_done and publish on the same cycle: both take effect, no loss.
- Both banks full: in_ready=0 in IDLE; stream stalls until frm_done.
- Reset mid-frame: partial frame lost, both banks empty.

Optional Feature:
MRD_SINK_ERRCNT_EN
- Defined: cnt_ok increments on each publish; cnt_err increments on each err_pts or err_len pulse. Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: counters are not synthesized; cnt_ok and cnt_err are tied to 0.

Test Plan:
- Legal frame: sop, dftpts=12, 12 samples, eop on 12th → wr_addr 0..11 on bank 0; frm_valid=1, frm_bank=0, frm_dftpts=12 two cycles after eop.
- Two frames, no frm_done → banks 0 and 1 full; in_ready=0 after second eop. Pulse frm_done → frm_bank=1, in_ready=1.
- Short frame: dftpts=24, eop on 10th sample → err_len one pulse, no publish, next legal frame lands in the same bank.
- Illegal size: sop with dftpts=6 (and again with 1300) → err_pts, samples through eop dropped, wr_en never asserted.
- Overlong frame: dftpts=12, no eop at 12th sample → err_len, DROP until eop, no publish. Mid-frame sop → restart at addr 0.
- Counters (with MRD_SINK_ERRCNT_EN): 3 good frames + 2 errors → cnt_ok=3, cnt_err=2. Without the macro, both read 0.
